// File: rtl/clkgen_pkg.sv
// Shared types and constants for the clock/reset generator.
// Holds the channel state encoding and the reset-stretcher sizing helpers.
package clkgen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } chan_state_t;

    localparam int SYNC_DEPTH = 2;

    // A zero hold still needs a one-bit counter so the port widths stay legal.
    function automatic int hold_cnt_width(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/clock_phase_chan.sv
// One generated clock channel: state machine, half-period counter, and the
// shadow/active configuration pair with its pending flag.
module clock_phase_chan
    import clkgen_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    input  logic             invert,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             busy,
    output logic             pend
);

    chan_state_t      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] sh_div_q, sh_phase_q;
    logic             sh_inv_q;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic [DIV_W-1:0] act_phase_q, act_phase_d;
    logic             act_inv_q, act_inv_d;
    logic             pend_q, pend_d;
    logic             adopt_in, adopt_sh;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adopt_in = 1'b0;
        adopt_sh = 1'b0;
        case (state_q)
            IDLE: begin
                // A load coinciding with start must not alter the run being started.
                if (start) begin
                    state_d  = DELAY;
                    cnt_d    = pend_q ? sh_phase_q : act_phase_q;
                    adopt_sh = pend_q;
                end else if (cfg_load) begin
                    adopt_in = 1'b1;
                end else if (pend_q) begin
                    adopt_sh = 1'b1;
                end
            end
            DELAY: begin
                if (!run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == act_div_q) begin
                    state_d = run ? LOW : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (!run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == act_div_q) begin
                    state_d  = HIGH;
                    cnt_d    = '0;
                    adopt_sh = pend_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        act_div_d   = act_div_q;
        act_phase_d = act_phase_q;
        act_inv_d   = act_inv_q;
        if (adopt_in) begin
            act_div_d   = div;
            act_phase_d = phase;
            act_inv_d   = invert;
        end else if (adopt_sh) begin
            act_div_d   = sh_div_q;
            act_phase_d = sh_phase_q;
            act_inv_d   = sh_inv_q;
        end

        pend_d = cfg_load ? !adopt_in : (pend_q && !adopt_sh);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_div_q    <= '0;
            sh_phase_q  <= '0;
            sh_inv_q    <= 1'b0;
            act_div_q   <= '0;
            act_phase_q <= '0;
            act_inv_q   <= 1'b0;
            pend_q      <= 1'b0;
            clk_out     <= 1'b0;
            rise_pulse  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_div_q   <= act_div_d;
            act_phase_q <= act_phase_d;
            act_inv_q   <= act_inv_d;
            pend_q      <= pend_d;
            if (cfg_load) begin
                sh_div_q   <= div;
                sh_phase_q <= phase;
                sh_inv_q   <= invert;
            end
            // Outputs come from the next state so they toggle on the same edge as the FSM.
            clk_out    <= (state_d == HIGH) ^ act_inv_d;
            rise_pulse <= (state_d == HIGH) && (state_q != HIGH);
        end
    end

    assign busy = (state_q != IDLE);
    assign pend = pend_q;

endmodule

// File: rtl/clock_phase_gen.sv
// Programmable multi-channel clock generator with a synchronised, stretched
// system reset; channels start together only from a fully idle state.
module clock_phase_gen
    import clkgen_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 4,
    parameter int RST_HOLD = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    cfg_load,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic [NUM_CH*DIV_W-1:0] phase,
    input  logic [NUM_CH-1:0]       invert,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       rise_pulse,
    output logic                    busy,
    output logic                    cfg_pend,
    output logic                    sys_rst_n
);

    localparam int HOLD_W = hold_cnt_width(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  sys_rst_d;
    logic [NUM_CH-1:0]     busy_vec, pend_vec;
    logic                  start;

    always_comb begin
        hold_d = hold_q;
        if (sync_q[SYNC_DEPTH-1] && (hold_q != HOLD_MAX))
            hold_d = hold_q + HOLD_W'(1);
        // Registering from the next count keeps the reset output glitch-free.
        if (RST_HOLD == 0)
            sys_rst_d = sync_q[SYNC_DEPTH-2];
        else
            sys_rst_d = sync_q[SYNC_DEPTH-1] && (hold_d == HOLD_MAX);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            hold_q    <= '0;
            sys_rst_n <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
            hold_q    <= hold_d;
            sys_rst_n <= sys_rst_d;
        end
    end

    assign start    = run && sys_rst_n && !busy;
    assign busy     = |busy_vec;
    assign cfg_pend = |pend_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clock_phase_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .start     (start),
            .run       (run),
            .cfg_load  (cfg_load),
            .div       (div[i*DIV_W +: DIV_W]),
            .phase     (phase[i*DIV_W +: DIV_W]),
            .invert    (invert[i]),
            .clk_out   (clk_out[i]),
            .rise_pulse(rise_pulse[i]),
            .busy      (busy_vec[i]),
            .pend      (pend_vec[i])
        );
    end

endmodule

// File: doc/clock_phase_gen.md
# clock_phase_gen

Parametrised clock-and-reset generator: the next generation of the fixed four-way clock fan-out at the top level. It produces NUM_CH registered, glitch-free divided clocks, e.g. for imem, dmem, processor and regfile. Each channel has a runtime-programmable divide ratio, start phase and polarity. It also provides a synchronised, stretched system reset, and sits directly under the top-level wrapper, between the board clock and all clocked elements.

## Interface
- NUM_CH, 4: number of output clock channels.
- DIV_W, 4: width of the per-channel divide and phase fields.
- RST_HOLD, 8: extra cycles sys_rst_n is held low after reset is synchronised.

- clock  in  1  master clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (polarity and synchronicity fixed).
- run  in  1  level; channels start when run=1, sys_rst_n=1 and all channels are idle.
- cfg_load  in  1  one-cycle strobe; captures div/phase/invert into the shadow registers.
- div  in  NUM_CH*DIV_W  per channel; half-period H = div+1 master cycles.
- phase  in  NUM_CH*DIV_W  per channel; start delay in master cycles.
- invert  in  NUM_CH  per channel; output polarity.
- clk_out  out  NUM_CH  generated clocks, driven directly from flops.
- rise_pulse  out  NUM_CH  high during the first cycle of each (pre-invert) high half.
- busy  out  1  any channel not IDLE.
- cfg_pend  out  1  shadow config not yet adopted by every channel.
- sys_rst_n  out  1  synchronised, stretched active-low system reset.

## Operation
- Per-channel FSM: IDLE, DELAY, HIGH, LOW. Internal level is 0 in IDLE/DELAY/LOW and 1 in HIGH. clk_out = level XOR active invert.
- Start: all channels IDLE, run=1 and sys_rst_n=1 at edge t0. Every channel loads its delay counter with phase and enters DELAY, or goes straight to HIGH at t0+1 when phase=0.
- DELAY: counts down, then HIGH. The first rise occurs at edge t0+1+phase.
- HIGH lasts H cycles, then LOW. LOW lasts H cycles, then HIGH. The period is 2H, so the minimum output is clock/2 and there is no pass-through mode.
- Stop on run=0:
  - DELAY or LOW: IDLE at the next edge.
  - HIGH: finishes the full high half, then IDLE.
  - No high pulse is ever shortened.
- Restart is only possible once busy=0. run=1 while stopping channels drain is held off until all are idle.
- Config adoption:
  - cfg_load writes the shadow registers and sets a per-channel pending bit.
  - An IDLE channel adopts at the next edge.
  - A running channel adopts at its LOW-to-HIGH boundary, so the new H governs the whole new high half.
  - The current half always completes with the old H.
  - A repeated cfg_load while pending overwrites the shadow; the pending bits stay set.
- cfg_pend is the OR of the pending bits.
- Active config reset values: div=0, phase=0, invert=0.
- sys_rst_n path:
  - 2-flop synchroniser on reset release.
  - Then a RST_HOLD counter.
  - sys_rst_n rises at rising edge 2+RST_HOLD after reset deasserts.

## Timing
- Reset values: clk_out=0, rise_pulse=0, busy=0, cfg_pend=0, sys_rst_n=0. All FSMs are IDLE and all counters 0.
- Reset asserted mid-operation:
  - Every flop clears immediately, asynchronously. A truncated clk_out pulse here is permitted.
  - sys_rst_n falls asynchronously.
- Latencies:
  - run to first rise: phase+1 edges.
  - cfg_load to cfg_pend=1: 1 edge.
  - cfg_load to idle adoption: 1 edge.
- rise_pulse is registered together with clk_out and is coincident with the pre-invert high half's first cycle.
- Simultaneous cfg_load and start edge: the channels start with the old config and adopt the new one at their first LOW-to-HIGH boundary.
- Simultaneous run falling and a HIGH-to-LOW boundary: go to IDLE, not LOW.
- Counter widths: DIV_W bits. div=2^DIV_W-1 gives H=2^DIV_W with no overflow (count 0..div).

## Structure
- clkgen_pkg holds:
  - the channel state enum (IDLE, DELAY, HIGH, LOW);
  - localparams for synchroniser depth (2) and RST_HOLD counter width ($clog2(RST_HOLD+1)).
- Sub-module clock_phase_chan: one channel's FSM, counter, shadow/active config and pending bit. It is instantiated NUM_CH times via generate.
- Top-level logic: start detection, busy/cfg_pend reduction and the sys_rst_n synchroniser/stretcher.

## Test plan
- Reset released, defaults, run=1 at t0:
  - sys_rst_n rises at edge 10 (RST_HOLD=8).
  - All clk_out rise at t0+1, with period 2 and in phase.
- ch1 div=2, phase=3, loaded while idle, then run: clk_out[1] rises at t0+4 and is high 3 / low 3. rise_pulse[1] occurs every 6 cycles.
- Running ch0 at div=1, cfg_load div=3 mid-HIGH:
  - cfg_pend=1.
  - The current high (2) and low (2) complete, then high 4 / low 4.
  - cfg_pend drops at the boundary.
- run=0 during the second cycle of a 3-cycle HIGH: the high completes (3 cycles), then clk_out stays low and busy=0 the next edge.
- invert[2]=1 loaded while idle: clk_out[2]=1 after one edge. Running output is the complement of the non-inverted waveform.
- reset asserted mid-run:
  - All outputs drop to 0 without a clock.
  - After release, sys_rst_n rises at edge 2+RST_HOLD and run is ignored before that.
